if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I CPU.
- Owns the PC and issues requests to the instruction cache.
- Absorbs multi-cycle cache latency, stalls and branch/jump redirects.
- Presents the decode stage with a fetched word, its PC, and the false_NOP flag that suppresses the control word for inserted bubbles.

Parameters:
- RESET_PC, 32'h0000_0060, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding placed in IF/ID for bubbles (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk edge.
- stall  in  1  hazard unit: hold IF/ID and PC this cycle.
- redirect  in  1  EX-stage taken branch/jal/jalr: flush and refetch.
- redirect_pc  in  32  target for redirect; bits [1:0] forced to 0 on load.
- inst_read  out  1  instruction cache request.
- inst_addr  out  32  request address (current PC).
- inst_resp  in  1  one-cycle pulse: inst_rdata valid.
- inst_rdata  in  32  fetched instruction word.
- if_id_pc  out  32  PC of instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID, feeds decode data input.
- false_NOP  out  1  1 = IF/ID holds an inserted bubble.

Behaviour:
- Reset (rst=0 at edge): pc=RESET_PC, state=FETCH, if_id_pc=0, if_id_instr=NOP_INSTR, false_NOP=1, skid buffer empty. While rst=0, inst_read=0.
- inst_addr = pc (combinational). inst_read = rst && (state==FETCH || state==DROP).
- Cache contract: once inst_read is asserted, inst_addr and inst_read stay stable until inst_resp. A request cannot be aborted.
- FSM states:
  - FETCH: request outstanding for pc.
  - HOLD: response captured in skid buffer, downstream stalled, inst_read=0.
  - DROP: outstanding response belongs to a stale pc and must be discarded.
- FETCH, inst_resp=1, redirect=0, stall=0: IF/ID <= {pc, inst_rdata, false_NOP=0}; pc <= pc+4 (mod 2^32); stay FETCH.
- FETCH, inst_resp=1, redirect=0, stall=1: buffer <= {pc, inst_rdata}; IF/ID holds; pc holds; go HOLD.
- FETCH, inst_resp=0, redirect=0: if stall=0, IF/ID <= bubble (pc unchanged, NOP_INSTR, false_NOP=1); if stall=1, IF/ID holds.
- HOLD, stall=0, redirect=0: IF/ID <= buffer with false_NOP=0; pc <= pc+4; go FETCH. Next request is issued the following cycle.
- HOLD, stall=1: everything holds.
- Redirect has priority over stall and inst_resp in every state:
  - pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble even if stall=1.
  - FETCH with inst_resp=0: go DROP, inst_addr keeps the old pc until the response arrives. pc is not updated yet; the target is held in pend_pc.
  - FETCH with inst_resp=1: discard data, go FETCH at the target.
  - HOLD: discard buffer, go FETCH at the target.
  - DROP: overwrite pend_pc with the newer target.
- DROP, inst_resp=1: discard data; pc <= pend_pc; go FETCH. While in DROP and stall=0, IF/ID <= bubbles.
- Stall is never applied to the cache side: a response arriving during a stall is buffered, never lost.
- Reset mid-fetch: state returns to FETCH with inst_read=0 for the reset cycle. A late inst_resp is tolerated only if the cache is reset simultaneously; it is not buffered.
- Throughput: 1 instr/cycle with single-cycle inst_resp. Latency from inst_resp to IF/ID = 1 edge.

Test Plan:
- Reset, then cache with 1-cycle latency returning words 0xA0, 0xA4, ... → if_id_pc sequence 0x60, 0x64, 0x68 on consecutive cycles, false_NOP=0, no gaps.
- Cache latency 3 cycles, stall=0 → two bubbles (if_id_instr=0x13, false_NOP=1) between valid instructions; inst_addr stable across the wait.
- inst_resp with stall=1 for 2 cycles → IF/ID unchanged, inst_read=0. On stall release the buffered word appears with correct pc, then pc advances by 4.
- redirect to 0x0000_0103 while a request to 0x70 is outstanding → inst_addr stays 0x70 until resp; that data is discarded. Next request is to 0x100. IF/ID shows bubbles meanwhile.
- redirect and stall both high with HOLD buffer full → IF/ID becomes bubble, buffer dropped, next inst_addr = target.
- rst=0 during a FETCH wait → next cycle pc=0x60, false_NOP=1, if_id_instr=0x13. inst_read reasserts the cycle after rst=1.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the RV32I pipeline.
// Owns the PC, talks to the instruction cache and absorbs latency, stalls and redirects.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        false_NOP
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] if_id_pc_n;
  logic [31:0] if_id_instr_n;
  logic        false_NOP_n;

  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4  = pc + 32'd4;
  assign inst_addr = pc;
  assign inst_read = rst && (state == FETCH || state == DROP);

  // Bubbles keep the old if_id_pc; only the instruction word and flag change.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_pc_n     = pend_pc;
    buf_pc_n      = buf_pc;
    buf_instr_n   = buf_instr;
    if_id_pc_n    = if_id_pc;
    if_id_instr_n = if_id_instr;
    false_NOP_n   = false_NOP;

    case (state)
      FETCH: begin
        if (redirect) begin
          if_id_instr_n = NOP_INSTR;
          false_NOP_n   = 1'b1;
          if (inst_resp) begin
            pc_n = target;
          end else begin
            pend_pc_n = target;
            state_n   = DROP;
          end
        end else if (inst_resp) begin
          if (stall) begin
            buf_pc_n    = pc;
            buf_instr_n = inst_rdata;
            state_n     = HOLD;
          end else begin
            if_id_pc_n    = pc;
            if_id_instr_n = inst_rdata;
            false_NOP_n   = 1'b0;
            pc_n          = pc_plus4;
          end
        end else if (!stall) begin
          if_id_instr_n = NOP_INSTR;
          false_NOP_n   = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          if_id_instr_n = NOP_INSTR;
          false_NOP_n   = 1'b1;
          pc_n          = target;
          state_n       = FETCH;
        end else if (!stall) begin
          if_id_pc_n    = buf_pc;
          if_id_instr_n = buf_instr;
          false_NOP_n   = 1'b0;
          pc_n          = pc_plus4;
          state_n       = FETCH;
        end
      end

      DROP: begin
        // The stale response still has to be consumed before fetching the target.
        if (redirect) begin
          if_id_instr_n = NOP_INSTR;
          false_NOP_n   = 1'b1;
          if (inst_resp) begin
            pc_n    = target;
            state_n = FETCH;
          end else begin
            pend_pc_n = target;
          end
        end else begin
          if (!stall) begin
            if_id_instr_n = NOP_INSTR;
            false_NOP_n   = 1'b1;
          end
          if (inst_resp) begin
            pc_n    = pend_pc;
            state_n = FETCH;
          end
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pend_pc     <= RESET_PC;
      buf_pc      <= 32'd0;
      buf_instr   <= NOP_INSTR;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      false_NOP   <= 1'b1;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_pc     <= pend_pc_n;
      buf_pc      <= buf_pc_n;
      buf_instr   <= buf_instr_n;
      if_id_pc    <= if_id_pc_n;
      if_id_instr <= if_id_instr_n;
      false_NOP   <= false_NOP_n;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed scenarios then random stall/redirect/reset traffic,
// checked against a queue-based fetch model and a variable-latency cache model.
module tb_if_id_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0060;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        false_NOP;

  if_id_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_read  (inst_read),
    .inst_addr  (inst_addr),
    .inst_resp  (inst_resp),
    .inst_rdata (inst_rdata),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr),
    .false_NOP  (false_NOP)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  int total = 0;
  int bad   = 0;

  // Reference model: fetch address, pending stale-response target, and held words.
  logic [31:0] m_addr;
  logic [31:0] m_target;
  bit          m_stale;
  entry_t      held[$];
  logic [31:0] m_ifpc;
  logic [31:0] m_ifinstr;
  logic        m_fnop;

  // Cache model: one outstanding request answered after a random latency.
  bit          c_busy;
  logic [31:0] c_addr;
  int          c_wait;
  int          lat_min;
  int          lat_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic r);
    check("inst_read", {31'd0, inst_read}, {31'd0, (r && held.size() == 0)});
    check("inst_addr", inst_addr, m_addr);
    check("if_id_instr", if_id_instr, m_ifinstr);
    check("false_NOP", {31'd0, false_NOP}, {31'd0, m_fnop});
    if (!m_fnop || !r) check("if_id_pc", if_id_pc, m_ifpc);
  endtask

  task automatic modelBubble();
    m_ifinstr = NOP_INSTR;
    m_fnop    = 1'b1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic d, input logic [31:0] rp);
    logic        resp;
    logic [31:0] data;
    logic [31:0] tgt;
    entry_t      e;
    rst         = r;
    stall       = s;
    redirect    = d;
    redirect_pc = rp;
    tgt         = rp & 32'hFFFF_FFFC;
    #1;
    resp = 1'b0;
    data = $urandom;
    if (!r) begin
      c_busy = 1'b0;
    end else begin
      if (c_busy) begin
        check("req_held", {31'd0, inst_read}, 32'd1);
        check("req_addr_stable", inst_addr, c_addr);
      end else if (held.size() == 0) begin
        c_busy = 1'b1;
        c_addr = m_addr;
        c_wait = $urandom_range(lat_max, lat_min) - 1;
      end
      if (c_busy) begin
        if (c_wait == 0) begin
          resp   = 1'b1;
          data   = c_addr + 32'h40;
          c_busy = 1'b0;
        end else begin
          c_wait--;
        end
      end
    end
    inst_resp  = resp;
    inst_rdata = data;

    if (!r) begin
      m_addr  = RESET_PC;
      m_stale = 1'b0;
      held.delete();
      m_ifpc  = 32'd0;
      modelBubble();
    end else if (d) begin
      modelBubble();
      if (held.size() == 0 && !resp) begin
        m_stale  = 1'b1;
        m_target = tgt;
      end else begin
        m_addr  = tgt;
        m_stale = 1'b0;
      end
      held.delete();
    end else if (held.size() != 0) begin
      if (!s) begin
        e         = held.pop_front();
        m_ifpc    = e.pc;
        m_ifinstr = e.instr;
        m_fnop    = 1'b0;
        m_addr    = e.pc + 32'd4;
      end
    end else if (resp) begin
      if (m_stale) begin
        m_addr  = m_target;
        m_stale = 1'b0;
        if (!s) modelBubble();
      end else if (s) begin
        held.push_back('{pc: m_addr, instr: data});
      end else begin
        m_ifpc    = m_addr;
        m_ifinstr = data;
        m_fnop    = 1'b0;
        m_addr    = m_addr + 32'd4;
      end
    end else if (!s) begin
      modelBubble();
    end

    @(posedge clk);
    #1;
    checkOutput(r);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    inst_resp = 1'b0; inst_rdata = 32'd0;
    c_busy = 1'b0; c_addr = 32'd0; c_wait = 0;
    lat_min = 1; lat_max = 1;
    m_addr = RESET_PC; m_target = RESET_PC; m_stale = 1'b0;
    m_ifpc = 32'd0; m_ifinstr = NOP_INSTR; m_fnop = 1'b1;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

    $display("[TB] single-cycle cache, back-to-back fetch");
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    check("seq_pc_after_5", if_id_pc, 32'h0000_0070);
    check("seq_instr_after_5", if_id_instr, 32'h0000_00B0);

    $display("[TB] three-cycle cache latency");
    lat_min = 3; lat_max = 3;
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] response during stall is buffered");
    lat_min = 1; lat_max = 1;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] redirect with request outstanding");
    lat_min = 3; lat_max = 3;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    check("redirect_target_addr", inst_addr, 32'h0000_0104);

    $display("[TB] redirect and stall with buffer full");
    lat_min = 1; lat_max = 1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("hold_redirect_addr", inst_addr, 32'h0000_0200);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] reset during fetch wait");
    lat_min = 3; lat_max = 3;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    check("rst_mid_addr", inst_addr, RESET_PC);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] random traffic");
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 50) != 0, ($urandom % 3) == 0,
                    ($urandom % 8) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
